param_write_scheduler: RTL and testbench



---
 rtl/param_sched_pkg.sv | 30 +++
 rtl/sched_fifo.sv | 70 +++++++
 rtl/param_write_scheduler.sv | 126 ++++++++++++
 tb/tb_param_write_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_sched_pkg.sv
// Shared types for the timestamp-driven parameter write scheduler:
// timestamp/counter widths, the queued entry record and the scheduler states.
package param_sched_pkg;

    localparam int TS_W       = 32;
    localparam int LATE_CNT_W = 16;
    localparam int AW_DEF     = 4;
    localparam int DW_DEF     = 32;

    // Entry record at the default address/data widths; parameterised users
    // build the same field order with entry_width().
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } sched_state_e;

    function automatic int entry_width(int aw, int dw);
        return TS_W + aw + dw;
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is readable as soon
// as the occupancy count shows it, one cycle after it was written.
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/param_write_scheduler.sv
// Applies queued (timestamp, address, data) parameter writes on their scheduled
// tick of a free-running timestamp, one registered write strobe per cycle.
module param_write_scheduler
    import param_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    flush_i,
    input  logic                    push_valid_i,
    output logic                    push_ready_o,
    input  logic [TS_W-1:0]         push_ts_i,
    input  logic [AW-1:0]           push_addr_i,
    input  logic [DW-1:0]           push_data_i,
    output logic [AW-1:0]           wr_addr_o,
    output logic [DW-1:0]           wr_data_o,
    output logic                    wr_stb_o,
    output logic                    late_o,
    output logic [LATE_CNT_W-1:0]   late_cnt_o,
    output logic [TS_W-1:0]         timestamp_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    busy_o
);

    localparam int EW = entry_width(AW, DW);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
    } sched_entry_t;

    sched_entry_t            head, push_entry;
    logic                    fifo_full, fifo_empty, push_fire, pop;
    sched_state_e            state_q, state_d;
    logic [TS_W-1:0]         ts_q, ts_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [DW-1:0]           wr_data_q, wr_data_d;
    logic                    late_q, late_d;
    logic [LATE_CNT_W-1:0]   late_cnt_q, late_cnt_d;

    // Handshake: an entry transfers on a cycle where push_valid_i and
    // push_ready_o are both high; ready reflects the registered occupancy only.
    assign push_ready_o = !fifo_full && !reset_i;
    assign push_fire    = push_valid_i && push_ready_o;
    assign push_entry   = '{ts: push_ts_i, addr: push_addr_i, data: push_data_i};

    sched_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .flush_i     (flush_i),
        .push_i      (push_fire),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d    = S_IDLE;
        pop        = 1'b0;
        ts_d       = ts_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        late_d     = 1'b0;
        late_cnt_d = late_cnt_q;

        if (enable_i) ts_d = ts_q + TS_W'(1);

        if (!fifo_empty && enable_i) begin
            if (head.ts > ts_q)  state_d = S_WAIT;
            else if (!flush_i)   state_d = S_ISSUE;
        end

        // ISSUE is only entered when the pop really happens, so the registered
        // state doubles as the write strobe.
        if (state_d == S_ISSUE) begin
            pop       = 1'b1;
            wr_addr_d = head.addr;
            wr_data_d = head.data;
            late_d    = (head.ts < ts_q);
            if (late_d && (late_cnt_q != '1)) late_cnt_d = late_cnt_q + 1'b1;
        end

        if (flush_i) begin
            ts_d       = '0;
            late_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            late_q     <= late_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    assign wr_stb_o    = (state_q == S_ISSUE);
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign late_o      = late_q;
    assign late_cnt_o  = late_cnt_q;
    assign timestamp_o = ts_q;
    assign busy_o      = !fifo_empty;

endmodule

// File: tb/tb_param_write_scheduler.sv
// Self-checking bench for param_write_scheduler: table-driven pushes with a
// strobe scoreboard, plus hand-written enable, fill, flush and reset sequences.
module tb_param_write_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CW    = 5;

    logic          clk_i = 1'b0;
    logic          reset_i, enable_i, flush_i, push_valid_i;
    logic [31:0]   push_ts_i;
    logic [AW-1:0] push_addr_i;
    logic [DW-1:0] push_data_i;
    logic          push_ready_o, wr_stb_o, late_o, busy_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [15:0]   late_cnt_o;
    logic [31:0]   timestamp_o;
    logic [CW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    param_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_ts_i    (push_ts_i),
        .push_addr_i  (push_addr_i),
        .push_data_i  (push_data_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_stb_o     (wr_stb_o),
        .late_o       (late_o),
        .late_cnt_o   (late_cnt_o),
        .timestamp_o  (timestamp_o),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [31:0]   ts;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   exp_ts;
        logic          exp_late;
    } vec_t;

    vec_t          vecs[5];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [68:0]   exp_q[$];
    logic [68:0]   mon_e;
    logic [31:0]   m_ts;

    // Reference timestamp, derived only from the driven inputs.
    always @(posedge clk_i) begin
        if (reset_i || flush_i) m_ts <= '0;
        else if (enable_i)      m_ts <= m_ts + 32'd1;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected {ts, late, addr, data}.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (wr_stb_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got ts=%0d addr=%0h data=%0h expected no strobe",
                             timestamp_o, wr_addr_o, wr_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe {ts,late,addr,data}",
                          {27'b0, timestamp_o, late_o, wr_addr_o, wr_data_o}, {27'b0, mon_e});
                end
            end else if (late_o) begin
                n_cmp++;
                n_fail++;
                $display("FAIL late_without_strobe: got late_o=1 expected 0");
            end
        end
    end

    task automatic apply_reset();
        reset_i      = 1'b1;
        enable_i     = 1'b0;
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        push_ts_i    = '0;
        push_addr_i  = '0;
        push_data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit exp_rdy, input bit track, input logic [31:0] exp_ts,
                        input bit exp_late);
        push_valid_i = 1'b1;
        push_ts_i    = t;
        push_addr_i  = a;
        push_data_i  = d;
        @(negedge clk_i);
        check("push_ready", {95'b0, push_ready_o}, {95'b0, exp_rdy});
        @(posedge clk_i);
        #1 push_valid_i = 1'b0;
        if (exp_rdy && track) exp_q.push_back({exp_ts, exp_late, a, d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timeout with %0d strobes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ts(input logic [31:0] t);
        int n = 0;
        while (m_ts != t && n < 2000) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (m_ts != t) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_ts: timeout, got model ts %0d expected %0d", m_ts, t);
        end
    endtask

    task automatic late_then_future();
        push(32'd0, 4'd1, 32'h0000_00A1, 1'b1, 1'b1, 32'd2, 1'b1);
        push(32'd0, 4'd2, 32'h0000_00A2, 1'b1, 1'b1, 32'd3, 1'b1);
        for (int k = 0; k < 4; k++)
            push(32'd900 + 32'(k), 4'(k), 32'(k), 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk_i);
        check("queued_count", 96'(count_o), 96'd4);
        check("queued_late_cnt", 96'(late_cnt_o), 96'd2);
        check("queued_busy", 96'(busy_o), 96'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0] = '{ts: 32'd10, addr: 4'd2, data: 32'h55, exp_ts: 32'd11, exp_late: 1'b0};
        vecs[1] = '{ts: 32'd5,  addr: 4'd1, data: 32'h1111_0005, exp_ts: 32'd6,  exp_late: 1'b0};
        vecs[2] = '{ts: 32'd7,  addr: 4'd3, data: 32'h2222_0007, exp_ts: 32'd8,  exp_late: 1'b0};
        vecs[3] = '{ts: 32'd7,  addr: 4'd4, data: 32'h3333_0007, exp_ts: 32'd9,  exp_late: 1'b1};
        vecs[4] = '{ts: 32'd9,  addr: 4'd9, data: 32'h4444_0009, exp_ts: 32'd10, exp_late: 1'b0};

        // Reset state
        apply_reset();
        @(negedge clk_i);
        check("reset_outputs",
              {wr_addr_o, wr_data_o, wr_stb_o, late_o, late_cnt_o, timestamp_o, count_o, busy_o}, '0);
        check("reset_ready", 96'(push_ready_o), 96'd1);

        // Single on-time write
        apply_reset();
        enable_i = 1'b1;
        push(vecs[0].ts, vecs[0].addr, vecs[0].data, 1'b1, 1'b1, vecs[0].exp_ts, vecs[0].exp_late);
        wait_drain("single", 100);
        @(negedge clk_i);
        check("single_late_cnt", 96'(late_cnt_o), 96'd0);
        check("single_hold", {wr_stb_o, wr_addr_o, wr_data_o}, {1'b0, 4'd2, 32'h55});

        // Ordered entries with a duplicated timestamp
        apply_reset();
        enable_i = 1'b1;
        for (int i = 1; i < 5; i++)
            push(vecs[i].ts, vecs[i].addr, vecs[i].data, 1'b1, 1'b1, vecs[i].exp_ts, vecs[i].exp_late);
        wait_drain("ordered", 100);
        @(negedge clk_i);
        check("ordered_late_cnt", 96'(late_cnt_o), 96'd1);

        // Fill to DEPTH with one shared timestamp, then overflow attempt
        apply_reset();
        enable_i = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push(32'd1000, 4'($urandom_range(0, 15)), $urandom, 1'b1, 1'b1, 32'd1001 + 32'(i), i != 0);
        @(negedge clk_i);
        check("full_count", 96'(count_o), 96'd16);
        @(posedge clk_i);
        #1;
        push(32'd1000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0, 1'b0);
        check("full_count_after_extra", 96'(count_o), 96'd16);
        wait_drain("fill", 1200);
        @(negedge clk_i);
        check("drained_count", 96'(count_o), 96'd0);
        check("drained_ready", 96'(push_ready_o), 96'd1);
        check("drained_busy", 96'(busy_o), 96'd0);
        check("fill_late_cnt", 96'(late_cnt_o), 96'd15);

        // Late entry pushed well after its timestamp
        apply_reset();
        enable_i = 1'b1;
        wait_ts(32'd80);
        push(32'd50, 4'd7, 32'hCAFE_F00D, 1'b1, 1'b1, 32'd82, 1'b1);
        wait_drain("late", 50);
        @(negedge clk_i);
        check("late_cnt", 96'(late_cnt_o), 96'd1);
        check("late_data", 96'(wr_data_o), 96'hCAFE_F00D);

        // enable_i low freezes the timestamp and holds the head
        apply_reset();
        enable_i = 1'b1;
        push(32'd22, 4'd3, 32'h0000_1234, 1'b1, 1'b1, 32'd23, 1'b0);
        wait_ts(32'd20);
        enable_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("frozen_ts", 96'(timestamp_o), 96'd20);
        check("frozen_count", 96'(count_o), 96'd1);
        enable_i = 1'b1;
        wait_drain("reenable", 50);

        // Flush with entries queued
        apply_reset();
        enable_i = 1'b1;
        late_then_future();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_state", {count_o, timestamp_o, late_cnt_o, busy_o}, '0);
        check("flush_wr_hold", {wr_addr_o, wr_data_o}, {4'd2, 32'h0000_00A2});
        repeat (30) @(posedge clk_i);
        #1;
        // Flush in the very cycle a due head is evaluated: no write may follow
        push(32'd0, 4'd5, 32'h0000_0BAD, 1'b1, 1'b0, 32'd0, 1'b0);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("flush_eval_state", {count_o, late_cnt_o, wr_data_o}, {5'd0, 16'd0, 32'h0000_00A2});

        // Reset mid-operation also clears the write outputs
        apply_reset();
        enable_i = 1'b1;
        late_then_future();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("midreset_state",
              {wr_addr_o, wr_data_o, count_o, timestamp_o, late_cnt_o, busy_o}, '0);
        check("midreset_ready", 96'(push_ready_o), 96'd1);
        repeat (20) @(posedge clk_i);
        #1;
        check("leftover_expected", 96'(exp_q.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
